// File: rtl/sevenseg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller and the SPI
// seven-seg slave: FSM state type, write-command encodings and the
// hex-to-segment decode used to build stored {dp, seg} patterns.
package sevenseg_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } scan_state_t;

   localparam logic [1:0] CMD_SHOW    = 2'b10;
   localparam logic [1:0] CMD_SHOW_DP = 2'b01;

   // Segment order {g,f,e,d,c,b,a}, active-high.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Returns {dp, seg}. Unused command codes blank the digit but light dp.
   function automatic logic [7:0] cmd_to_pattern(input logic [1:0] cmd,
                                                 input logic [3:0] nib);
      logic [7:0] p;
      case (cmd)
         CMD_SHOW:    p = {1'b0, hex_to_seg(nib)};
         CMD_SHOW_DP: p = {1'b1, hex_to_seg(nib)};
         default:     p = 8'h80;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Digit-write handshake: a write transfers on a rising clk edge when
// wr_valid and wr_ready are both high.
//   wr_valid  master->slave  write request
//   wr_ready  slave->master  write accept
//   wr_digit  master->slave  target digit index
//   wr_cmd    master->slave  show / show+dp / blank command
//   wr_data   master->slave  hex nibble
interface sevenseg_scan_ctrl_if #(
   parameter int N_DIGITS = 4
);
   logic                        wr_valid;
   logic                        wr_ready;
   logic [$clog2(N_DIGITS)-1:0] wr_digit;
   logic [1:0]                  wr_cmd;
   logic [3:0]                  wr_data;

   modport master (output wr_valid, wr_digit, wr_cmd, wr_data, input wr_ready);
   modport slave  (input wr_valid, wr_digit, wr_cmd, wr_data, output wr_ready);
endinterface

// File: rtl/sevenseg_digit_ram.sv
// N_DIGITS x 8 pattern store, one synchronous write port and one
// combinational read port. Entries clear to 00 on reset.
//   clk, rst_n   clock, async active-low reset
//   we/waddr/wdata  write port
//   raddr/rdata     read port
module sevenseg_digit_ram #(
   parameter int N_DIGITS = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        we,
   input  logic [$clog2(N_DIGITS)-1:0] waddr,
   input  logic [7:0]                  wdata,
   input  logic [$clog2(N_DIGITS)-1:0] raddr,
   output logic [7:0]                  rdata
);
   localparam int IDX_W = $clog2(N_DIGITS);

   logic [7:0] mem [N_DIGITS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_DIGITS; i++) mem[i] <= 8'h00;
      end else begin
         for (int i = 0; i < N_DIGITS; i++)
            if (we && (waddr == IDX_W'(i))) mem[i] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller. Each digit is lit for the
// dwell period, followed by BLANK_CYC dark cycles, then the next digit.
//   clk, rst_n        clock, async active-low reset
//   enable            scan enable (0 forces OFF)
//   dwell_ld/dwell_val  dwell-period register load
//   wr                digit-write handshake (slave side)
//   seg, dp, dig_en   registered display drive
//   scan_idx          current / next digit index
//   frame_done        one-cycle pulse after each full scan
//
// state | meaning
// OFF   | display dark, scan_idx = 0, waiting for enable
// SHOW  | digit scan_idx lit with pattern latched on entry
// BLANK | all dark between digits, scan_idx still the last shown digit
module sevenseg_scan_ctrl
   import sevenseg_scan_ctrl_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int DWELL_W   = 16,
   parameter int BLANK_CYC = 2,
   parameter int DWELL_RST = 1000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        dwell_ld,
   input  logic [DWELL_W-1:0]          dwell_val,
   sevenseg_scan_ctrl_if.slave         wr,
   output logic [6:0]                  seg,
   output logic                        dp,
   output logic [N_DIGITS-1:0]         dig_en,
   output logic [$clog2(N_DIGITS)-1:0] scan_idx,
   output logic                        frame_done
);
   localparam int IDX_W = $clog2(N_DIGITS);
   localparam int CNT_W = (DWELL_W > 4) ? DWELL_W : 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

   scan_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, show_len_m1;
   logic [IDX_W-1:0] idx_nxt;
   logic [DWELL_W-1:0] dwell_q;
   logic             show_entry, fd_nxt, wr_fire;
   logic [7:0]       ram_rdata, wr_pat, entry_pat;

   assign wr.wr_ready = !((state == ST_SHOW) && (wr.wr_digit == scan_idx));
   assign wr_fire     = wr.wr_valid && wr.wr_ready && (32'(wr.wr_digit) < N_DIGITS);
   assign wr_pat      = cmd_to_pattern(wr.wr_cmd, wr.wr_data);

   // A write landing on the same edge as this digit's SHOW entry bypasses
   // the store so the new pattern is what gets latched.
   assign entry_pat = (wr_fire && (wr.wr_digit == idx_nxt)) ? wr_pat : ram_rdata;

   // Dwell of zero is treated as a single cycle.
   assign show_len_m1 = (dwell_q == '0) ? '0 : CNT_W'(dwell_q) - CNT_W'(1);

   sevenseg_digit_ram #(.N_DIGITS(N_DIGITS)) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_fire),
      .waddr (wr.wr_digit),
      .wdata (wr_pat),
      .raddr (idx_nxt),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        dwell_q <= DWELL_W'(DWELL_RST);
      else if (dwell_ld) dwell_q <= dwell_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_OFF;
         cnt        <= '0;
         scan_idx   <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         scan_idx   <= idx_nxt;
         frame_done <= fd_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      idx_nxt    = scan_idx;
      fd_nxt     = 1'b0;
      show_entry = 1'b0;
      if (!enable) begin
         state_nxt = ST_OFF;
         cnt_nxt   = '0;
         idx_nxt   = '0;
      end else begin
         case (state)
            ST_OFF: begin
               state_nxt  = ST_SHOW;
               idx_nxt    = '0;
               show_entry = 1'b1;
            end
            ST_SHOW: begin
               if (cnt == '0) begin
                  state_nxt = ST_BLANK;
                  cnt_nxt   = CNT_W'(BLANK_CYC - 1);
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            ST_BLANK: begin
               if (cnt == '0) begin
                  state_nxt  = ST_SHOW;
                  show_entry = 1'b1;
                  if (scan_idx == LAST_IDX) begin
                     idx_nxt = '0;
                     fd_nxt  = 1'b1;
                  end else begin
                     idx_nxt = scan_idx + IDX_W'(1);
                  end
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            default: state_nxt = ST_OFF;
         endcase
         if (show_entry) cnt_nxt = show_len_m1;
      end
   end

   // Display drive is registered alongside the state so it tracks the
   // state cycle-for-cycle; the pattern is frozen for the whole SHOW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg    <= '0;
         dp     <= 1'b0;
         dig_en <= '0;
      end else if (show_entry) begin
         {dp, seg} <= entry_pat;
         dig_en    <= {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_nxt;
      end else if (state_nxt != ST_SHOW) begin
         seg    <= '0;
         dp     <= 1'b0;
         dig_en <= '0;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
module tb_sevenseg_scan_ctrl;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n, enable, dwell_ld;
   logic [15:0] dwell_val;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  dig_en;
   logic [1:0]  scan_idx;
   logic        frame_done;

   sevenseg_scan_ctrl_if #(.N_DIGITS(N)) wr_if ();

   sevenseg_scan_ctrl #(
      .N_DIGITS(N), .DWELL_W(16), .BLANK_CYC(2), .DWELL_RST(1000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .dwell_ld   (dwell_ld),
      .dwell_val  (dwell_val),
      .wr         (wr_if),
      .seg        (seg),
      .dp         (dp),
      .dig_en     (dig_en),
      .scan_idx   (scan_idx),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] dig;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
      logic [1:0] idx;
   } exp_t;

   exp_t       sb [$];
   logic [7:0] pat [N];
   int         errors = 0;
   int         checks = 0;
   int         wait_n;
   int         sd [24] = '{0, 0, 0, -1, -1, 1, -1, -1, 2, -1, -1, 3,
                           -1, -1, 0, -1, -1, 1, -1, -1, 2, -1, -1, 3};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input int d, input logic fd, input logic [1:0] idx);
      exp_t e;
      e.fd  = fd;
      e.idx = idx;
      if (d < 0) begin
         e.dig = 4'h0;
         e.seg = 7'h00;
         e.dp  = 1'b0;
      end else begin
         e.dig = 4'(1 << d);
         {e.dp, e.seg} = pat[d];
      end
      return e;
   endfunction

   // Fixed dwell=3, blank=2 frame of 20 cycles.
   function automatic exp_t frame_exp(input int k);
      int d, ph;
      d  = (k / 5) % 4;
      ph = k % 5;
      return mk((ph < 3) ? d : -1, (k > 0) && (k % 20 == 0), 2'(d));
   endfunction

   function automatic exp_t dwell_exp(input int c);
      int last;
      last = 0;
      for (int j = 0; j <= c; j++) if (sd[j] >= 0) last = sd[j];
      return mk(sd[c], c == 14, 2'(last));
   endfunction

   task automatic pop_chk(input string tag);
      exp_t e, o;
      o = {dig_en, seg, dp, frame_done, scan_idx};
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty observed=%h", tag, o);
      end else begin
         e = sb.pop_front();
         chk(tag, 32'(o), 32'(e));
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; dwell_ld = 1'b0; dwell_val = '0;
      wr_if.wr_valid = 1'b0; wr_if.wr_digit = '0; wr_if.wr_cmd = '0; wr_if.wr_data = '0;
      foreach (pat[i]) pat[i] = 8'h00;

      #12;
      chk("rst_seg", 32'(seg), 0);
      chk("rst_dp", 32'(dp), 0);
      chk("rst_dig_en", 32'(dig_en), 0);
      chk("rst_scan_idx", 32'(scan_idx), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_wr_ready", 32'(wr_if.wr_ready), 1);

      // Release reset, load dwell=3, write digit2 = 9 while OFF.
      @(negedge clk);
      rst_n = 1'b1; dwell_ld = 1'b1; dwell_val = 16'd3;
      wr_if.wr_valid = 1'b1; wr_if.wr_digit = 2'd2; wr_if.wr_cmd = 2'b10; wr_if.wr_data = 4'h9;
      pat[2] = 8'h6F;

      // Digit3 blank-with-dp command.
      @(negedge clk);
      chk("off_dig_en", 32'(dig_en), 0);
      chk("off_wr_ready", 32'(wr_if.wr_ready), 1);
      dwell_ld = 1'b0;
      wr_if.wr_digit = 2'd3; wr_if.wr_cmd = 2'b11; wr_if.wr_data = 4'h5;
      pat[3] = 8'h80;

      @(negedge clk);
      wr_if.wr_valid = 1'b0; wr_if.wr_digit = 2'd0;
      enable = 1'b1;
      sb.push_back(frame_exp(0));

      for (int k = 0; k <= 70; k++) begin
         @(negedge clk);
         pop_chk("frame");
         chk("wr_ready", 32'(wr_if.wr_ready),
             32'(!(((k % 5) < 3) && (wr_if.wr_digit == 2'((k / 5) % 4)))));
         if (k == 45) begin
            wr_if.wr_valid = 1'b1; wr_if.wr_digit = 2'd1;
            wr_if.wr_cmd = 2'b01; wr_if.wr_data = 4'hA;
         end
         if (k == 49) begin
            wr_if.wr_valid = 1'b0; wr_if.wr_digit = 2'd0;
            pat[1] = 8'hF7;
         end
         if (k < 70) sb.push_back(frame_exp(k + 1));
      end

      // Disable mid-SHOW.
      enable = 1'b0;
      sb.push_back(mk(-1, 1'b0, 2'd0));
      @(negedge clk);
      pop_chk("disable");

      // Re-enable; shrink dwell to 0 mid-SHOW; write digit2 on its entry edge.
      enable = 1'b1;
      sb.push_back(dwell_exp(0));
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         pop_chk("dwell");
         if (c == 1) begin dwell_ld = 1'b1; dwell_val = 16'd0; end
         if (c == 2) dwell_ld = 1'b0;
         if (c == 7) begin
            wr_if.wr_valid = 1'b1; wr_if.wr_digit = 2'd2;
            wr_if.wr_cmd = 2'b10; wr_if.wr_data = 4'h7;
            pat[2] = 8'h07;
         end
         if (c == 8) begin wr_if.wr_valid = 1'b0; wr_if.wr_digit = 2'd0; end
         if (c < 23) sb.push_back(dwell_exp(c + 1));
      end

      // Reset pulse during digit3 SHOW.
      rst_n = 1'b0;
      #1;
      chk("arst_dig_en", 32'(dig_en), 0);
      chk("arst_seg", 32'(seg), 0);
      chk("arst_dp", 32'(dp), 0);
      chk("arst_scan_idx", 32'(scan_idx), 0);
      @(negedge clk);
      rst_n = 1'b1;
      foreach (pat[i]) pat[i] = 8'h00;
      sb.push_back(mk(0, 1'b0, 2'd0));
      @(negedge clk);
      pop_chk("post_rst");

      // Dwell back at its reset value; shorten it and confirm digit2 store cleared.
      dwell_ld = 1'b1; dwell_val = 16'd1;
      @(negedge clk);
      dwell_ld = 1'b0;
      wait_n = 0;
      while (dig_en !== 4'b0100 && wait_n < 3000) begin
         @(negedge clk);
         wait_n++;
      end
      if (wait_n >= 3000) begin
         checks++;
         errors++;
         $error("FAIL ram_clr_timeout observed dig_en=%h expected=4", dig_en);
      end else begin
         chk("ram_clr_pat", 32'({dp, seg}), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
